// File: rtl/traffic_light_gen.sv
// Two-road highway/farm traffic light controller with programmable phase timing,
// debounced farm sensor, all-red clearance and a maintenance flash mode.
module traffic_light_gen #(
    parameter int CNT_W      = 16,
    parameter int HG_MIN     = 8,
    parameter int Y_TIME     = 3,
    parameter int AR_TIME    = 1,
    parameter int FG_MIN     = 4,
    parameter int FG_MAX     = 10,
    parameter int DEB        = 2,
    parameter int FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       C,
    input  logic       flash_mode,
    output logic [2:0] light_highway,
    output logic [2:0] light_farm,
    output logic [2:0] phase_o
);

    typedef enum logic [2:0] {
        HG    = 3'd0,
        HY    = 3'd1,
        AR1   = 3'd2,
        FG    = 3'd3,
        FY    = 3'd4,
        AR2   = 3'd5,
        FLASH = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_G    = 3'b001;
    localparam logic [2:0] LAMP_Y    = 3'b010;
    localparam logic [2:0] LAMP_R    = 3'b100;
    localparam logic [2:0] LAMP_DARK = 3'b000;

    localparam int DEB_W = $clog2(DEB + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB);

    localparam logic [CNT_W-1:0] HG_LAST     = CNT_W'(HG_MIN - 1);
    localparam logic [CNT_W-1:0] Y_LAST      = CNT_W'(Y_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(AR_TIME - 1);
    localparam logic [CNT_W-1:0] FG_MIN_LAST = CNT_W'(FG_MIN - 1);
    localparam logic [CNT_W-1:0] FG_MAX_LAST = CNT_W'(FG_MAX - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_HALF - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   timer;
    logic [CNT_W-1:0]   timer_nxt;
    logic               flash_tgl;
    logic               tgl_nxt;
    logic               c_s1;
    logic               c_s2;
    logic [DEB_W-1:0]   deb_cnt;
    logic               car;
    logic               req;

    assign car = (deb_cnt == DEB_MAX);
    assign req = car | flash_mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HG;
            timer     <= '0;
            flash_tgl <= 1'b0;
            c_s1      <= 1'b0;
            c_s2      <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            flash_tgl <= tgl_nxt;
            c_s1      <= C;
            c_s2      <= c_s1;
            if (!c_s2)
                deb_cnt <= '0;
            else if (deb_cnt != DEB_MAX)
                deb_cnt <= deb_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer + 1'b1;
        tgl_nxt       = flash_tgl;
        light_highway = LAMP_R;
        light_farm    = LAMP_R;

        case (state)
            HG: begin
                light_highway = LAMP_G;
                // Timer parks at HG_LAST while waiting for a request
                if (timer >= HG_LAST) begin
                    timer_nxt = timer;
                    if (req) begin
                        state_nxt = HY;
                        timer_nxt = '0;
                    end
                end
            end
            HY: begin
                light_highway = LAMP_Y;
                if (timer == Y_LAST) begin
                    state_nxt = AR1;
                    timer_nxt = '0;
                end
            end
            AR1: begin
                if (timer == AR_LAST) begin
                    state_nxt = flash_mode ? FLASH : FG;
                    timer_nxt = '0;
                end
            end
            FG: begin
                light_farm = LAMP_G;
                if ((timer == FG_MAX_LAST) ||
                    ((timer >= FG_MIN_LAST) && (!car || flash_mode))) begin
                    state_nxt = FY;
                    timer_nxt = '0;
                end
            end
            FY: begin
                light_farm = LAMP_Y;
                if (timer == Y_LAST) begin
                    state_nxt = AR2;
                    timer_nxt = '0;
                end
            end
            AR2: begin
                if (timer == AR_LAST) begin
                    state_nxt = flash_mode ? FLASH : HG;
                    timer_nxt = '0;
                end
            end
            FLASH: begin
                light_highway = flash_tgl ? LAMP_DARK : LAMP_Y;
                light_farm    = flash_tgl ? LAMP_DARK : LAMP_R;
                // Leaving flash is only allowed on a half-period boundary
                if (timer == FLASH_LAST) begin
                    timer_nxt = '0;
                    if (flash_mode) begin
                        tgl_nxt = ~flash_tgl;
                    end else begin
                        tgl_nxt   = 1'b0;
                        state_nxt = AR2;
                    end
                end
            end
            default: begin
                state_nxt = HG;
                timer_nxt = '0;
                tgl_nxt   = 1'b0;
            end
        endcase
    end

    assign phase_o = state;

endmodule

// File: tb/tb_traffic_light_gen.sv
// Directed scoreboard bench for traffic_light_gen with default parameters:
// expected lamp/phase values are queued per cycle and popped after each clock edge.
module tb_traffic_light_gen;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] D = 3'b000;

    logic       clk;
    logic       rst_n;
    logic       C;
    logic       flash_mode;
    logic [2:0] light_highway;
    logic [2:0] light_farm;
    logic [2:0] phase_o;

    int checks;
    int failures;

    typedef struct {
        logic [8:0] v;
        string      tag;
    } exp_t;

    exp_t sb[$];

    traffic_light_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .C            (C),
        .flash_mode   (flash_mode),
        .light_highway(light_highway),
        .light_farm   (light_farm),
        .phase_o      (phase_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic is_go(input logic [2:0] l);
        return (l == G) || (l == Y);
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert ({light_highway, light_farm, phase_o} === e.v)
        else begin
            failures++;
            $error("FAIL %s observed hw=%b farm=%b phase=%0d required hw=%b farm=%b phase=%0d",
                   e.tag, light_highway, light_farm, phase_o, e.v[8:6], e.v[5:3], e.v[2:0]);
        end
        checks++;
        assert ((is_go(light_highway) && is_go(light_farm)) === 1'b0)
        else begin
            failures++;
            $error("FAIL safety_%s observed hw=%b farm=%b required not both G/Y",
                   e.tag, light_highway, light_farm);
        end
    endtask

    task automatic run(input int n, input logic [2:0] hw, input logic [2:0] fm,
                       input logic [2:0] ph, input string tag);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.v   = {hw, fm, ph};
            e.tag = tag;
            sb.push_back(e);
            tick();
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        run(1, G, R, 3'd0, tag);
        rst_n = 1'b1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        C          = 1'b0;
        flash_mode = 1'b0;

        // Idle: highway green held forever
        do_reset("reset");
        run(50, G, R, 3'd0, "idle_hg");

        // Car held from reset release: full cycle with max-out, then reset in FG
        do_reset("reset2");
        C = 1'b1;
        run(7, G, R, 3'd0, "car_hg");
        run(3, Y, R, 3'd1, "car_hy");
        run(1, R, R, 3'd2, "car_ar1");
        run(10, R, G, 3'd3, "car_fg_maxout");
        run(3, R, Y, 3'd4, "car_fy");
        run(1, R, R, 3'd5, "car_ar2");
        run(8, G, R, 3'd0, "car_hg2");
        run(3, Y, R, 3'd1, "car_hy2");
        run(1, R, R, 3'd2, "car_ar1_2");
        run(6, R, G, 3'd3, "car_fg2");
        rst_n = 1'b0;
        run(1, G, R, 3'd0, "rst_in_fg");
        rst_n = 1'b1;
        run(7, G, R, 3'd0, "post_rst_hg");
        run(3, Y, R, 3'd1, "post_rst_hy");

        // Six-cycle pulse after HG minimum: debounce latency then gap-out
        C = 1'b0;
        do_reset("reset3");
        run(9, G, R, 3'd0, "gap_hg_wait");
        C = 1'b1;
        run(4, G, R, 3'd0, "gap_hg_deb");
        run(2, Y, R, 3'd1, "gap_hy");
        C = 1'b0;
        run(1, Y, R, 3'd1, "gap_hy");
        run(1, R, R, 3'd2, "gap_ar1");
        run(4, R, G, 3'd3, "gap_fg");
        run(3, R, Y, 3'd4, "gap_fy");
        run(1, R, R, 3'd5, "gap_ar2");
        run(5, G, R, 3'd0, "gap_hg");

        // Single-cycle glitch is rejected by the debouncer
        do_reset("reset4");
        run(9, G, R, 3'd0, "glitch_pre");
        C = 1'b1;
        run(1, G, R, 3'd0, "glitch_hi");
        C = 1'b0;
        run(20, G, R, 3'd0, "glitch_hold");

        // Flash entry, two full half periods, drop mid-half
        do_reset("reset5");
        run(10, G, R, 3'd0, "fl_hg");
        flash_mode = 1'b1;
        run(3, Y, R, 3'd1, "fl_hy");
        run(1, R, R, 3'd2, "fl_ar1");
        run(4, Y, R, 3'd6, "fl_on0");
        run(4, D, D, 3'd6, "fl_off0");
        run(4, Y, R, 3'd6, "fl_on1");
        run(2, D, D, 3'd6, "fl_off1");
        flash_mode = 1'b0;
        run(2, D, D, 3'd6, "fl_off1_end");
        run(1, R, R, 3'd5, "fl_ar2");
        run(5, G, R, 3'd0, "fl_hg_back");

        // Flash withdrawn during HY: normal farm service
        do_reset("reset6");
        run(9, G, R, 3'd0, "wd_hg");
        flash_mode = 1'b1;
        run(1, Y, R, 3'd1, "wd_hy");
        flash_mode = 1'b0;
        run(2, Y, R, 3'd1, "wd_hy");
        run(1, R, R, 3'd2, "wd_ar1");
        run(4, R, G, 3'd3, "wd_fg");
        run(3, R, Y, 3'd4, "wd_fy");
        run(1, R, R, 3'd5, "wd_ar2");
        run(3, G, R, 3'd0, "wd_hg2");

        // Reset during FLASH dark half, then re-entry starts with toggle 0
        do_reset("reset7");
        flash_mode = 1'b1;
        run(7, G, R, 3'd0, "fr_hg");
        run(3, Y, R, 3'd1, "fr_hy");
        run(1, R, R, 3'd2, "fr_ar1");
        run(4, Y, R, 3'd6, "fr_on");
        run(2, D, D, 3'd6, "fr_off");
        rst_n      = 1'b0;
        flash_mode = 1'b0;
        run(1, G, R, 3'd0, "rst_in_flash");
        rst_n = 1'b1;
        run(5, G, R, 3'd0, "fr_hg_after");
        flash_mode = 1'b1;
        run(2, G, R, 3'd0, "fr_hg_req");
        run(3, Y, R, 3'd1, "fr_hy2");
        run(1, R, R, 3'd2, "fr_ar1_2");
        run(4, Y, R, 3'd6, "fr_reentry_on");
        flash_mode = 1'b0;
        run(1, R, R, 3'd5, "fr_exit_ar2");
        run(3, G, R, 3'd0, "fr_exit_hg");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
